// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer: power-on init and 32-character refresh of a 16x2
// HD44780-class LCD over an 8-bit write-only bus. All outputs are registered.
module lcd_frame_sequencer #(
  parameter int PWR_WAIT_CYC = 20000,
  parameter int E_HIGH_CYC   = 4,
  parameter int SETTLE_CYC   = 50,
  parameter int CLEAR_CYC    = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_100hz,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       frame_done
);
  localparam int T_WR  = 1 + E_HIGH_CYC + SETTLE_CYC;
  localparam int MAX_A = (PWR_WAIT_CYC > CLEAR_CYC) ? PWR_WAIT_CYC : CLEAR_CYC;
  localparam int MAX_C = (MAX_A > T_WR) ? MAX_A : T_WR;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_PWR, S_INIT, S_CLR, S_IDLE, S_ADDR, S_FETCH, S_DATA
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;     // shared: power wait, clear wait, write phase, fetch
  logic [1:0]    step_q;    // which init command is on the bus
  logic [4:0]    index_q;
  logic [7:0]    data_q;
  logic          rs_q, e_q, busy_q, done_q, pend_q;

  // Write phase: cnt 0 = setup, 1..E_HIGH_CYC = strobe high, rest = settle.
  logic wr_last, e_next;
  assign wr_last = (cnt_q == CW'(T_WR - 1));
  assign e_next  = (cnt_q < CW'(E_HIGH_CYC));

  function automatic logic [7:0] init_cmd(input logic [1:0] s);
    case (s)
      2'd0:    init_cmd = 8'h38;  // 8-bit bus, 2 lines, 5x8
      2'd1:    init_cmd = 8'h0C;  // display on, no cursor
      2'd2:    init_cmd = 8'h06;  // increment, no shift
      default: init_cmd = 8'h01;  // clear
    endcase
  endfunction

  // Sequencer: power wait, init commands, then frames of address/data writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_PWR;
      cnt_q   <= '0;
      step_q  <= 2'd0;
      index_q <= 5'd0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Requests arriving while not idle are remembered once.
      if (state_q != S_IDLE && en_100hz) pend_q <= 1'b1;
      case (state_q)
        S_PWR: begin
          if (cnt_q == CW'(PWR_WAIT_CYC - 1)) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            step_q  <= 2'd0;
            data_q  <= init_cmd(2'd0);
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_INIT: begin
          if (!wr_last) begin
            cnt_q <= cnt_q + 1'b1;
            e_q   <= e_next;
          end else begin
            cnt_q <= '0;
            e_q   <= 1'b0;
            if (step_q == 2'd3) begin
              if (CLEAR_CYC == 0) begin
                state_q <= S_IDLE;
                busy_q  <= pend_q | en_100hz;
              end else begin
                state_q <= S_CLR;
              end
            end else begin
              step_q <= step_q + 2'd1;
              data_q <= init_cmd(step_q + 2'd1);
            end
          end
        end
        S_CLR: begin
          if (cnt_q == CW'(CLEAR_CYC - 1)) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= pend_q | en_100hz;  // no busy gap on a pending hand-off
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (en_100hz || pend_q) begin
            state_q <= S_ADDR;
            pend_q  <= 1'b0;
            index_q <= 5'd0;
            cnt_q   <= '0;
            data_q  <= 8'h80;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_ADDR: begin
          if (!wr_last) begin
            cnt_q <= cnt_q + 1'b1;
            e_q   <= e_next;
          end else begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            e_q     <= 1'b0;
          end
        end
        S_FETCH: begin
          // Two cycles: index reaches the display block, its char comes back registered.
          if (cnt_q == CW'(1)) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            data_q  <= char_in;
            rs_q    <= 1'b1;
            e_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (!wr_last) begin
            cnt_q <= cnt_q + 1'b1;
            e_q   <= e_next;
          end else begin
            cnt_q <= '0;
            e_q   <= 1'b0;
            if (index_q == 5'd31) begin
              state_q <= S_IDLE;
              index_q <= 5'd0;
              done_q  <= 1'b1;
              busy_q  <= pend_q | en_100hz;
            end else begin
              index_q <= index_q + 5'd1;
              if (index_q == 5'd15) begin
                state_q <= S_ADDR;
                data_q  <= 8'hC0;
                rs_q    <= 1'b0;
              end else begin
                state_q <= S_FETCH;
              end
            end
          end
        end
        default: state_q <= S_PWR;
      endcase
    end
  end

  assign index      = index_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_e      = e_q;
  assign lcd_data   = data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
endmodule
